// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS sequencer.
// Holds opcode and ALU-control constants, the FSM state enum, the mux-select
// encodings, the latched instruction class and the Moore output decoder.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b001011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b011000;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_RTYPE = 6'b100010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10
  } pc_src_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL, CLS_LW, CLS_SW, CLS_ADDI, CLS_SUBI,
    CLS_R, CLS_BEQ, CLS_BNE, CLS_J
  } iclass_t;

  // Outputs that depend only on state (and the latched class), so they can
  // be computed for the next state and registered.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    pc_src_t    pc_src;
    logic       alusrc_a;
    srcb_t      alusrc_b;
    logic [3:0] aluctl;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } moore_t;

  function automatic iclass_t decode_class(input logic [5:0] op);
    case (op)
      OP_LW:    return CLS_LW;
      OP_SW:    return CLS_SW;
      OP_ADDI:  return CLS_ADDI;
      OP_SUBI:  return CLS_SUBI;
      OP_RTYPE: return CLS_R;
      OP_BEQ:   return CLS_BEQ;
      OP_BNE:   return CLS_BNE;
      OP_J:     return CLS_J;
      default:  return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic moore_t moore_of(input state_t s, input iclass_t c,
                                      input logic [3:0] fn_lo);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.mem_req  = 1'b1;
        m.alusrc_b = SRCB_FOUR;
        m.aluctl   = ALU_ADD;
      end
      S_DECODE: begin
        m.alusrc_b = SRCB_IMM_SH2;
        m.aluctl   = ALU_ADD;
      end
      S_MEMADR, S_EXEC_I: begin
        m.alusrc_a = 1'b1;
        m.alusrc_b = SRCB_IMM;
        m.aluctl   = (s == S_EXEC_I && c == CLS_SUBI) ? ALU_SUB : ALU_ADD;
      end
      S_MEM_RD: begin
        m.mem_req = 1'b1;
        m.iord    = 1'b1;
      end
      S_MEM_WR: begin
        m.mem_req = 1'b1;
        m.mem_we  = 1'b1;
        m.iord    = 1'b1;
      end
      S_MEM_WB: begin
        m.regwrite = 1'b1;
        m.memtoreg = 1'b1;
      end
      S_EXEC_R: begin
        m.alusrc_a = 1'b1;
        m.alusrc_b = SRCB_RT;
        m.aluctl   = fn_lo;
      end
      S_ALU_WB: begin
        m.regwrite = 1'b1;
        m.regdst   = (c == CLS_R);
      end
      S_BRANCH: begin
        m.alusrc_a = 1'b1;
        m.alusrc_b = SRCB_RT;
        m.aluctl   = ALU_SUB;
        m.pc_src   = PCSRC_ALUOUT;
      end
      S_JUMP:  m.pc_src = PCSRC_JUMP;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bundle between the sequencer and the datapath/memory.
// master: sequencer side (drives controls, receives IR fields, zero, mem_ready).
// slave:  datapath side.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alusrc_a;
  logic [1:0] alusrc_b;
  logic [3:0] aluctl;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       retire;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alusrc_a, alusrc_b, aluctl, regdst, memtoreg, regwrite,
           retire, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alusrc_a, alusrc_b, aluctl, regdst, memtoreg, regwrite,
           retire, illegal
  );
endinterface

// File: rtl/mc_ctrl_perf.sv
// mc_ctrl_perf: retired-instruction and memory-stall counters.
// Ports: clk, rst_n (async active-low), retire, stall (per-cycle events),
// perf_retired, perf_stall (free-running, wrap modulo 2^CNT_W).
module mc_ctrl_perf #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             retire,
  input  logic             stall,
  output logic [CNT_W-1:0] perf_retired,
  output logic [CNT_W-1:0] perf_stall
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (retire) perf_retired <= perf_retired + 1'b1;
      if (stall)  perf_stall   <= perf_stall + 1'b1;
    end
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS sequencer (fetch/decode/execute/mem/wb)
// sharing one ALU and one unified memory port.
// Ports: clk, rst_n (async active-low), bus (mc_ctrl_if.master: IR fields,
// zero, memory handshake and all datapath controls).
// Optional MC_CTRL_PERF_EN adds perf_retired / perf_stall counter outputs.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  mc_ctrl_if.master bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_retired,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  state_t  state, state_nxt;
  iclass_t cls, cls_nxt;
  moore_t  mo, mo_nxt;
  logic    br_taken;

  always_comb begin
    state_nxt = state;
    cls_nxt   = cls;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        cls_nxt = decode_class(bus.opcode);
        case (cls_nxt)
          CLS_LW, CLS_SW:     state_nxt = S_MEMADR;
          CLS_ADDI, CLS_SUBI: state_nxt = S_EXEC_I;
          CLS_R:              state_nxt = S_EXEC_R;
          CLS_BEQ, CLS_BNE:   state_nxt = S_BRANCH;
          CLS_J:              state_nxt = S_JUMP;
          default:            state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR: if (bus.mem_ready) state_nxt = S_FETCH;
      S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
    // Outputs are precomputed for the state being entered so they leave the
    // flops glitch-free; EXEC_R is only entered from DECODE, where funct is
    // the live IR field.
    mo_nxt = moore_of(state_nxt, cls_nxt, bus.funct[3:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cls   <= CLS_ILLEGAL;
      mo    <= '0;
    end else begin
      state <= state_nxt;
      cls   <= cls_nxt;
      mo    <= mo_nxt;
    end
  end

  assign bus.mem_req  = mo.mem_req;
  assign bus.mem_we   = mo.mem_we;
  assign bus.iord     = mo.iord;
  assign bus.pc_src   = mo.pc_src;
  assign bus.alusrc_a = mo.alusrc_a;
  assign bus.alusrc_b = mo.alusrc_b;
  assign bus.aluctl   = mo.aluctl;
  assign bus.regdst   = mo.regdst;
  assign bus.memtoreg = mo.memtoreg;
  assign bus.regwrite = mo.regwrite;

  // Pulses qualified by same-cycle inputs (mem_ready, zero, opcode) cannot be
  // registered without adding a cycle, so they are decoded from state here.
  assign br_taken     = (cls == CLS_BEQ) ? bus.zero : !bus.zero;
  assign bus.ir_write = (state == S_FETCH) && bus.mem_ready;
  assign bus.pc_write = ((state == S_FETCH) && bus.mem_ready) ||
                        ((state == S_BRANCH) && br_taken) ||
                        (state == S_JUMP);
  assign bus.retire   = (state == S_MEM_WB) || (state == S_ALU_WB) ||
                        (state == S_BRANCH) || (state == S_JUMP) ||
                        ((state == S_MEM_WR) && bus.mem_ready);
  assign bus.illegal  = (state == S_DECODE) &&
                        (decode_class(bus.opcode) == CLS_ILLEGAL);

`ifdef MC_CTRL_PERF_EN
  mc_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire       (bus.retire),
    .stall        (mo.mem_req && !bus.mem_ready),
    .perf_retired (perf_retired),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. The driver plays
// instructions cycle by cycle, pushing the expected control word for every
// cycle; a monitor pops and compares on each falling edge.
module tb_multicycle_ctrl;

  localparam int K_LW = 0, K_SW = 1, K_ADDI = 2, K_SUBI = 3, K_R = 4,
                 K_BEQ = 5, K_BNE = 6, K_J = 7, K_ILL = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [3:0] aluctl;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       retire;
    logic       illegal;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();

`ifdef MC_CTRL_PERF_EN
  logic [31:0] perf_retired, perf_stall;
  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .perf_retired(perf_retired), .perf_stall(perf_stall)
  );
`else
  multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  ctl_t sb[$];
  int   sb_tag[$];
  int   tests = 0;
  int   fails = 0;
  int   cur_tag = 0;
  int   exp_retired = 0;
  int   exp_stall = 0;
  bit   drv_done = 1'b0;

  function automatic ctl_t observe();
    ctl_t g;
    g.mem_req  = bus.mem_req;   g.mem_we   = bus.mem_we;
    g.iord     = bus.iord;      g.ir_write = bus.ir_write;
    g.pc_write = bus.pc_write;  g.pc_src   = bus.pc_src;
    g.alusrc_a = bus.alusrc_a;  g.alusrc_b = bus.alusrc_b;
    g.aluctl   = bus.aluctl;    g.regdst   = bus.regdst;
    g.memtoreg = bus.memtoreg;  g.regwrite = bus.regwrite;
    g.retire   = bus.retire;    g.illegal  = bus.illegal;
    return g;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000011, 6'b001011, 6'b001000, 6'b011000,
                      6'b110100, 6'b110101, 6'b100010, 6'b000010};
  endfunction

  // One clock of stimulus: apply inputs, record the expected control word.
  task automatic step(input ctl_t e, input logic mr, input logic [5:0] op,
                      input logic [5:0] fn, input logic z);
    bus.mem_ready = mr;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    sb.push_back(e);
    sb_tag.push_back(cur_tag);
    if (rst_n && e.mem_req && !mr) exp_stall++;
    if (rst_n && e.retire) exp_retired++;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one instruction, phase by phase. fst/mst are the
  // number of mem_ready=0 cycles in fetch and in the data access; cut stops
  // an sw inside its write wait (used for the mid-access reset).
  task automatic do_instr(input int kind, input logic [5:0] fn, input int fst,
                          input int mst, input logic z, input bit cut);
    ctl_t e;
    logic [5:0] op;
    case (kind)
      K_LW:    op = 6'b000011;
      K_SW:    op = 6'b001011;
      K_ADDI:  op = 6'b001000;
      K_SUBI:  op = 6'b011000;
      K_R:     op = 6'b100010;
      K_BEQ:   op = 6'b110100;
      K_BNE:   op = 6'b110101;
      K_J:     op = 6'b000010;
      default: begin
        op = r6();
        while (is_legal(op)) op = r6();
      end
    endcase
    cur_tag++;

    e = '0; e.mem_req = 1'b1; e.alusrc_b = 2'b01; e.aluctl = 4'd2;
    for (int i = 0; i < fst; i++) step(e, 1'b0, r6(), r6(), rbit());
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(e, 1'b1, r6(), r6(), rbit());

    // Only the decode cycle carries the real opcode/funct.
    e = '0; e.alusrc_b = 2'b11; e.aluctl = 4'd2; e.illegal = (kind == K_ILL);
    step(e, rbit(), op, fn, rbit());

    case (kind)
      K_LW, K_SW: begin
        e = '0; e.alusrc_a = 1'b1; e.alusrc_b = 2'b10; e.aluctl = 4'd2;
        step(e, rbit(), r6(), r6(), rbit());
        e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (kind == K_SW);
        for (int i = 0; i < mst; i++) step(e, 1'b0, r6(), r6(), rbit());
        if (!cut) begin
          e.retire = (kind == K_SW);
          step(e, 1'b1, r6(), r6(), rbit());
          if (kind == K_LW) begin
            e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.retire = 1'b1;
            step(e, rbit(), r6(), r6(), rbit());
          end
        end
      end
      K_ADDI, K_SUBI: begin
        e = '0; e.alusrc_a = 1'b1; e.alusrc_b = 2'b10;
        e.aluctl = (kind == K_ADDI) ? 4'd2 : 4'd6;
        step(e, rbit(), r6(), r6(), rbit());
        e = '0; e.regwrite = 1'b1; e.retire = 1'b1;
        step(e, rbit(), r6(), r6(), rbit());
      end
      K_R: begin
        e = '0; e.alusrc_a = 1'b1; e.alusrc_b = 2'b00; e.aluctl = fn[3:0];
        step(e, rbit(), r6(), r6(), rbit());
        e = '0; e.regwrite = 1'b1; e.regdst = 1'b1; e.retire = 1'b1;
        step(e, rbit(), r6(), r6(), rbit());
      end
      K_BEQ, K_BNE: begin
        e = '0; e.alusrc_a = 1'b1; e.alusrc_b = 2'b00; e.aluctl = 4'd6;
        e.pc_src = 2'b01; e.retire = 1'b1;
        e.pc_write = (kind == K_BEQ) ? z : !z;
        step(e, rbit(), r6(), r6(), z);
      end
      K_J: begin
        e = '0; e.pc_src = 2'b10; e.pc_write = 1'b1; e.retire = 1'b1;
        step(e, rbit(), r6(), r6(), rbit());
      end
      default: ;
    endcase
  endtask

`ifdef MC_CTRL_PERF_EN
  task automatic check_perf(input string tag);
    tests++;
    if (perf_retired !== 32'(exp_retired)) begin
      fails++;
      $display("FAIL perf_retired(%s): got %0d want %0d", tag, perf_retired, exp_retired);
    end
    tests++;
    if (perf_stall !== 32'(exp_stall)) begin
      fails++;
      $display("FAIL perf_stall(%s): got %0d want %0d", tag, perf_stall, exp_stall);
    end
  endtask
`endif

  // Monitor: compares the DUT control word against the scoreboard.
  initial begin
    ctl_t e, g;
    int   t;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        t = sb_tag.pop_front();
        g = observe();
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL ctl instr %0d: got %h want %h", t, g, e);
        end
      end
    end
  end

  // Driver.
  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b0; bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step('0, 1'b1, r6(), r6(), rbit());   // held in reset: all outputs 0
    rst_n = 1'b1;
    step('0, 1'b1, r6(), r6(), rbit());   // IDLE

    do_instr(K_R,    6'b100000, 0, 0, 1'b0, 1'b0);  // add
    do_instr(K_LW,   r6(),      0, 3, 1'b0, 1'b0);  // lw, 3 wait cycles
    do_instr(K_BEQ,  r6(),      0, 0, 1'b1, 1'b0);
    do_instr(K_BNE,  r6(),      0, 0, 1'b1, 1'b0);
    do_instr(K_ILL,  r6(),      0, 0, 1'b0, 1'b0);  // random illegal
    cur_tag++;
    begin
      ctl_t e;
      // Explicit 111111 illegal opcode.
      e = '0; e.mem_req = 1'b1; e.alusrc_b = 2'b01; e.aluctl = 4'd2;
      e.ir_write = 1'b1; e.pc_write = 1'b1;
      step(e, 1'b1, r6(), r6(), rbit());
      e = '0; e.alusrc_b = 2'b11; e.aluctl = 4'd2; e.illegal = 1'b1;
      step(e, 1'b1, 6'b111111, r6(), rbit());
    end
    do_instr(K_SW,   r6(),      1, 2, 1'b0, 1'b0);
    do_instr(K_ADDI, r6(),      0, 0, 1'b0, 1'b0);
    do_instr(K_SUBI, r6(),      2, 0, 1'b0, 1'b0);
    do_instr(K_J,    r6(),      0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++)
      do_instr(int'($urandom_range(0, 8)), r6(), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), rbit(), 1'b0);

`ifdef MC_CTRL_PERF_EN
    check_perf("run");
`endif

    // Reset asserted mid-way through an sw write wait.
    do_instr(K_SW, r6(), 0, 2, 1'b0, 1'b1);
    bus.mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.push_back('0);           // mem_req/mem_we must already be low
    sb_tag.push_back(cur_tag);
    exp_retired = 0;
    exp_stall   = 0;
    @(posedge clk);
    #1;
`ifdef MC_CTRL_PERF_EN
    check_perf("reset");
`endif
    rst_n = 1'b1;
    step('0, 1'b1, r6(), r6(), rbit());   // IDLE after release
    for (int n = 0; n < 6; n++)
      do_instr(int'($urandom_range(0, 8)), r6(), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), rbit(), 1'b0);
`ifdef MC_CTRL_PERF_EN
    check_perf("post");
`endif
    drv_done = 1'b1;
  end

  // End of test: let the monitor drain, then report.
  initial begin
    int guard;
    guard = 0;
    while (!drv_done && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (!drv_done) begin
      fails++;
      $display("FAIL driver_timeout: got unfinished want finished");
    end
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. Steps each instruction through fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one unified memory port. Drives PC/IR write enables, mux selects, ALU control and the memory request handshake. It replaces the single-cycle combinational decoder when the core is built multi-cycle.

## Interface
- CNT_W, 32, width of performance counters (used only with MC_CTRL_PERF_EN)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_req, mem_we, iord  out  1 each  memory request, write, address select (0=PC, 1=ALUOut)
- ir_write, pc_write  out  1 each  IR load, PC load
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alusrc_a  out  1  0=PC, 1=rs
- alusrc_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- aluctl  out  4  ALU operation
- regdst, memtoreg, regwrite  out  1 each  writeback controls
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse in DECODE on an unknown opcode
- perf_retired, perf_stall  out  CNT_W each  present only with MC_CTRL_PERF_EN

## Operation
- Opcodes: lw 000011, sw 001011, addi 001000, subi 011000, beq 110100, bne 110101, R-type 100010, j 000010.
- aluctl codes: add 4'd2, sub 4'd6; R-type uses funct[3:0].
- Moore outputs decoded from state; an unlisted output is 0 in that state.
- IDLE: all outputs 0 -> FETCH.
- FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluctl=2, pc_src=00. Holds while !mem_ready. On mem_ready: ir_write=1, pc_write=1 in that same cycle -> DECODE.
- DECODE: alusrc_a=0, alusrc_b=11, aluctl=2 (branch target to ALUOut). Latch the instruction class. Next state: lw/sw->MEMADR, addi/subi->EXEC_I, R->EXEC_R, beq/bne->BRANCH, j->JUMP, other->FETCH with illegal=1 and no retire.
- MEMADR: alusrc_a=1, alusrc_b=10, aluctl=2 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, iord=1. Wait for mem_ready -> MEM_WB.
- MEM_WB: regwrite=1, regdst=0, memtoreg=1, retire=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Wait for mem_ready; then retire=1 -> FETCH.
- EXEC_R: alusrc_a=1, alusrc_b=00, aluctl=funct[3:0] -> ALU_WB.
- EXEC_I: alusrc_a=1, alusrc_b=10, aluctl=2 (addi) or 6 (subi) -> ALU_WB.
- ALU_WB: regwrite=1, memtoreg=0, regdst=1 for R and 0 for I, retire=1 -> FETCH.
- BRANCH: alusrc_a=1, alusrc_b=00, aluctl=6, pc_src=01. pc_write = zero for beq, !zero for bne. retire=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, retire=1 -> FETCH.

## Timing
- Reset: state=IDLE; every output 0; counters 0. Reset mid-access drops mem_req asynchronously, abandons the instruction, and restarts at IDLE.
- Handshake: once mem_req rises, mem_req, mem_we and iord stay stable until the cycle mem_ready=1. mem_ready is ignored when mem_req=0.
- Zero-wait cycle counts: R/addi/subi 4, lw 5, sw 4, beq/bne/j 3, illegal 2. Each mem_ready=0 cycle adds one.
- Instruction class is latched in DECODE, so later states do not depend on opcode staying stable.

## Configuration
- MC_CTRL_PERF_EN defined: perf_retired increments on retire. perf_stall increments each cycle with mem_req && !mem_ready. Both wrap modulo 2^CNT_W.
- Not defined: perf ports and counter logic are absent; all other behaviour is identical.

## Structure
- mc_ctrl_pkg: opcode localparams, aluctl constants, state enum, alusrc_b and pc_src encodings, instruction-class enum.
- Sub-module mc_ctrl_perf holds the two counters; it is instantiated only under MC_CTRL_PERF_EN.

## Test plan
- Reset release, mem_ready=1: IDLE then FETCH with mem_req=1, iord=0. The next edge pulses ir_write and pc_write, with pc_src=00 and alusrc_b=01.
- add (100010, funct 100000), zero-wait: 4 cycles from FETCH; aluctl=0 in EXEC_R; ALU_WB has regwrite=1, regdst=1; retire pulses once.
- lw with mem_ready low for 3 cycles in MEM_RD: mem_req and iord=1 held stable; 8 cycles total; perf_stall=3 with PERF_EN.
- beq with zero=1: pc_write=1, pc_src=01. bne with zero=1: pc_write=0. Both take 3 cycles and retire.
- Opcode 111111: illegal pulses in DECODE, then FETCH; no retire, no regwrite.
- rst_n low during a MEM_WR wait: mem_req and mem_we drop immediately; after release, state is IDLE and counters are 0.
